// File: rtl/ycseq.sv
// Clocked sequencer for one asynchronous dual-rail yellow-cell chain: inject, filter, capture,
// return to empty, then hand the captured code to a clocked consumer.
module ycseq #(
    parameter int SYNC_STAGES = 2,
    parameter int CW          = 8,
    parameter int TIMEOUT     = 200
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic       req_data,
    input  logic [1:0] req_match,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic [1:0] rsp_data,
    input  logic       err_clr,
    output logic       err,
    output logic [1:0] err_code,
    output logic       busy,
    output logic [1:0] cell_in,
    output logic [1:0] cell_match,
    input  logic [1:0] cell_out
);

    // state | meaning
    // IDLE  | cell empty, waiting for a request (and for the consumer to take any result)
    // SET   | data driven into the cell, waiting for a stable nonzero cell_out
    // CLEAR | cell driven to empty, waiting for cell_out to drain back to 00
    // ERR   | hung or illegal cell; cell held empty until err_clr
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SET   = 2'd1,
        CLEAR = 2'd2,
        ERR   = 2'd3
    } state_t;

    localparam logic [CW-1:0] TO_CNT = CW'(TIMEOUT);

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
    logic [1:0]    cell_in_q, cell_in_d;
    logic [1:0]    cell_match_q, cell_match_d;
    logic [1:0]    rsp_data_q, rsp_data_d;
    logic          rsp_valid_q, rsp_valid_d;
    logic          err_q, err_d;
    logic [1:0]    err_code_q, err_code_d;
    logic [1:0]    last_q, last_d;
    logic [1:0]    sync_q [SYNC_STAGES];
    logic [1:0]    sync_d [SYNC_STAGES];
    logic [1:0]    out_s;
    logic          accept;

    assign out_s     = sync_q[SYNC_STAGES-1];
    assign req_ready = (state_q == IDLE) && !rsp_valid_q;
    assign accept    = req_valid && req_ready;
    assign busy      = (state_q == SET) || (state_q == CLEAR);
    assign cnt_inc   = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;

    always_comb begin
        sync_d[0] = cell_out;
        for (int i = 1; i < SYNC_STAGES; i++) begin
            sync_d[i] = sync_q[i-1];
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        cell_in_d    = cell_in_q;
        cell_match_d = cell_match_q;
        rsp_data_d   = rsp_data_q;
        rsp_valid_d  = rsp_valid_q;
        err_d        = err_q;
        err_code_d   = err_code_q;
        last_d       = out_s;

        if (rsp_valid_q && rsp_ready) begin
            rsp_valid_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d      = SET;
                    cell_in_d    = req_data ? 2'b10 : 2'b01;
                    cell_match_d = req_match;
                    cnt_d        = '0;
                end
            end
            SET: begin
                cnt_d = cnt_inc;
                if (out_s == 2'b11) begin
                    state_d    = ERR;
                    err_code_d = 2'b11;
                end else if (out_s != 2'b00 && out_s == last_q) begin
                    // two equal consecutive samples reject single-cycle glitches
                    state_d    = CLEAR;
                    rsp_data_d = out_s;
                    cell_in_d  = 2'b00;
                    cnt_d      = '0;
                end else if (cnt_q == TO_CNT) begin
                    state_d    = ERR;
                    err_code_d = 2'b01;
                end
            end
            CLEAR: begin
                cnt_d = cnt_inc;
                if (out_s == 2'b00) begin
                    state_d     = IDLE;
                    rsp_valid_d = 1'b1;
                end else if (out_s == 2'b11) begin
                    state_d    = ERR;
                    err_code_d = 2'b11;
                end else if (cnt_q == TO_CNT) begin
                    state_d    = ERR;
                    err_code_d = 2'b10;
                end
            end
            ERR: begin
                if (err_clr) begin
                    state_d    = IDLE;
                    err_d      = 1'b0;
                    err_code_d = 2'b00;
                end
            end
            default: state_d = IDLE;
        endcase

        if (state_d == ERR && state_q != ERR) begin
            err_d        = 1'b1;
            cell_in_d    = 2'b00;
            cell_match_d = 2'b00;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            cell_in_q    <= 2'b00;
            cell_match_q <= 2'b00;
            rsp_data_q   <= 2'b00;
            rsp_valid_q  <= 1'b0;
            err_q        <= 1'b0;
            err_code_q   <= 2'b00;
            last_q       <= 2'b00;
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= 2'b00;
            end
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            cell_in_q    <= cell_in_d;
            cell_match_q <= cell_match_d;
            rsp_data_q   <= rsp_data_d;
            rsp_valid_q  <= rsp_valid_d;
            err_q        <= err_d;
            err_code_q   <= err_code_d;
            last_q       <= last_d;
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_d[i];
            end
        end
    end

    assign cell_in    = cell_in_q;
    assign cell_match = cell_match_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_data   = rsp_data_q;
    assign err        = err_q;
    assign err_code   = err_code_q;

endmodule

// File: tb/tb_ycseq.sv
// Scoreboard bench for ycseq: directed requests against a behavioural cell (pass-through or
// hand-driven), responses and error events checked by a separate monitor.
module tb_ycseq;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       req_valid = 1'b0;
    logic       req_ready;
    logic       req_data = 1'b0;
    logic [1:0] req_match = 2'b00;
    logic       rsp_valid;
    logic       rsp_ready = 1'b0;
    logic [1:0] rsp_data;
    logic       err_clr = 1'b0;
    logic       err;
    logic [1:0] err_code;
    logic       busy;
    logic [1:0] cell_in;
    logic [1:0] cell_match;
    logic [1:0] cell_out;

    logic       man_mode = 1'b0;
    logic [1:0] cell_man = 2'b00;

    // pass-through ycfsm model when match=11, or a hand-driven output
    assign cell_out = man_mode ? cell_man : ((cell_match == 2'b11) ? cell_in : 2'b00);

    ycseq #(.SYNC_STAGES(2), .CW(8), .TIMEOUT(200)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_data(req_data), .req_match(req_match),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .err_clr(err_clr), .err(err), .err_code(err_code), .busy(busy),
        .cell_in(cell_in), .cell_match(cell_match), .cell_out(cell_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit         is_err;
        logic [1:0] data;
    } exp_t;

    exp_t sb[$];
    int   n_pass = 0;
    int   n_tot  = 0;
    logic err_prev = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    task automatic push(input bit is_err, input logic [1:0] data);
        exp_t e;
        e.is_err = is_err;
        e.data   = data;
        sb.push_back(e);
    endtask

    // monitor: a handshake or a rising err is one observed output event
    always @(negedge clk) begin
        exp_t e;
        if (!reset && rsp_valid && rsp_ready) begin
            if (sb.size() == 0) chk("sb_underflow_rsp", 32'(sb.size()), 32'd1);
            else begin
                e = sb.pop_front();
                chk("rsp_kind", 32'(0), 32'(e.is_err));
                chk("rsp_data", 32'(rsp_data), 32'(e.data));
            end
        end
        if (err && !err_prev) begin
            if (sb.size() == 0) chk("sb_underflow_err", 32'(sb.size()), 32'd1);
            else begin
                e = sb.pop_front();
                chk("err_kind", 32'(1), 32'(e.is_err));
                chk("err_code", 32'(err_code), 32'(e.data));
            end
        end
        err_prev = err;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_accept(input logic d, input logic [1:0] m);
        int k = 0;
        while (!req_ready && k < 100) begin
            tick();
            k++;
        end
        chk("req_ready_before_accept", 32'(req_ready), 32'd1);
        req_valid = 1'b1;
        req_data  = d;
        req_match = m;
        tick();
        req_valid = 1'b0;
    endtask

    task automatic wait_rsp(input int budget, output int cycles);
        cycles = 0;
        while (!rsp_valid && cycles < budget) begin
            tick();
            cycles++;
        end
        chk("rsp_valid_seen", 32'(rsp_valid), 32'd1);
    endtask

    task automatic wait_err(input int budget, output int cycles);
        cycles = 0;
        while (!err && cycles < budget) begin
            tick();
            cycles++;
        end
        chk("err_seen", 32'(err), 32'd1);
    endtask

    task automatic handshake();
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        chk("rsp_valid_cleared", 32'(rsp_valid), 32'd0);
    endtask

    task automatic clear_err();
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        chk("err_cleared", 32'(err), 32'd0);
        chk("err_code_cleared", 32'(err_code), 32'd0);
        chk("req_ready_after_clr", 32'(req_ready), 32'd1);
    endtask

    initial begin
        int n;
        logic [1:0] held;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_cell_in", 32'(cell_in), 32'd0);
        chk("rst_cell_match", 32'(cell_match), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_data", 32'(rsp_data), 32'd0);
        chk("rst_err", 32'({err, err_code}), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        reset = 1'b0;
        tick();
        chk("idle_req_ready", 32'(req_ready), 32'd1);

        // pass-through cell, data 1: seven cycles from accept to rsp_valid
        push(1'b0, 2'b10);
        do_accept(1'b1, 2'b11);
        chk("set_cell_in", 32'(cell_in), 32'h2);
        chk("set_cell_match", 32'(cell_match), 32'h3);
        chk("set_busy", 32'(busy), 32'd1);
        wait_rsp(50, n);
        chk("latency", 32'(n), 32'd7);
        chk("rsp_err_low", 32'(err), 32'd0);
        chk("match_held", 32'(cell_match), 32'h3);
        handshake();

        // data 0 then consumer stalls 20 cycles while a new request waits
        push(1'b0, 2'b01);
        do_accept(1'b0, 2'b11);
        chk("set_cell_in_0", 32'(cell_in), 32'h1);
        wait_rsp(50, n);
        chk("latency_0", 32'(n), 32'd7);
        held = rsp_data;
        req_valid = 1'b1;
        req_data  = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            chk("stall_rsp_valid", 32'(rsp_valid), 32'd1);
            chk("stall_rsp_data", 32'(rsp_data), 32'(held));
            chk("stall_req_ready", 32'(req_ready), 32'd0);
            chk("stall_no_accept", 32'(cell_in), 32'd0);
        end
        req_valid = 1'b0;
        handshake();

        // cell output stuck empty: SET timeout after 201 cycles
        man_mode = 1'b1;
        cell_man = 2'b00;
        push(1'b1, 2'b01);
        do_accept(1'b1, 2'b11);
        wait_err(400, n);
        chk("set_timeout_cycles", 32'(n), 32'd201);
        chk("err_cell_in", 32'(cell_in), 32'd0);
        chk("err_cell_match", 32'(cell_match), 32'd0);
        chk("err_busy", 32'(busy), 32'd0);
        chk("err_no_rsp", 32'(rsp_valid), 32'd0);
        repeat (3) tick();
        chk("err_sticky", 32'({err, err_code}), 32'h5);
        clear_err();

        // cell output stuck 10 through the clear phase: CLEAR timeout
        push(1'b1, 2'b10);
        do_accept(1'b1, 2'b11);
        cell_man = 2'b10;
        wait_err(600, n);
        chk("clr_to_rsp_data", 32'(rsp_data), 32'h2);
        chk("clr_to_no_rsp", 32'(rsp_valid), 32'd0);
        cell_man = 2'b00;
        clear_err();

        // single-cycle 01 glitch then a settled 10
        push(1'b0, 2'b10);
        do_accept(1'b1, 2'b11);
        @(negedge clk);
        cell_man = 2'b01;
        @(negedge clk);
        cell_man = 2'b10;
        repeat (10) tick();
        chk("glitch_in_clear", 32'(cell_in), 32'd0);
        cell_man = 2'b00;
        wait_rsp(50, n);
        handshake();

        // illegal code 11 on cell_out during SET
        push(1'b1, 2'b11);
        do_accept(1'b0, 2'b11);
        cell_man = 2'b11;
        wait_err(50, n);
        cell_man = 2'b00;
        clear_err();

        // asynchronous reset mid-SET
        do_accept(1'b1, 2'b11);
        repeat (5) tick();
        chk("pre_reset_busy", 32'(busy), 32'd1);
        #2 reset = 1'b1;
        #1;
        chk("async_rst_cell_in", 32'(cell_in), 32'd0);
        chk("async_rst_busy", 32'(busy), 32'd0);
        chk("async_rst_rsp_valid", 32'(rsp_valid), 32'd0);
        #1 reset = 1'b0;
        tick();
        chk("post_reset_ready", 32'(req_ready), 32'd1);
        repeat (10) tick();
        chk("post_reset_no_rsp", 32'(rsp_valid), 32'd0);

        repeat (3) tick();
        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish, got running expected done");
        $fatal(1);
    end

endmodule
